// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the load/store bus sequencer.
//   - opcode constants for the handled loads and stores
//   - FSM state enum
//   - decode helpers: is_load, is_store, be_for (byteenable), misaligned
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_ERR,
        ST_TERR
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: r = 1'b1;
            default:                                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        logic r;
        case (op)
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // LWL/LWR select the partial-word lanes that the formatter merges.
    function automatic logic [3:0] be_for(input logic [5:0] op, input logic [1:0] off);
        logic [3:0] be;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << off;
            OP_LH, OP_LHU, OP_SH: be = off[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            OP_LWL:               be = 4'b1111 << (2'd3 - off);
            OP_LWR:               be = 4'b1111 >> off;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        logic m;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = off[0];
            OP_LW, OP_SW:         m = (off != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align.sv
// store_align: places store data onto the big-endian byte lanes of the bus.
//   rt_data_i  store source register
//   opcode_i   instruction opcode
//   wdata_o    lane-replicated / byte-swapped writedata (0 for non-stores)
module store_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] rt_data_i,
    input  logic [5:0]  opcode_i,
    output logic [31:0] wdata_o
);

    always_comb begin
        wdata_o = 32'h0;
        case (opcode_i)
            // Replicate so the byteenable alone picks the destination lane.
            OP_SB: wdata_o = {4{rt_data_i[7:0]}};
            OP_SH: wdata_o = {2{rt_data_i[7:0], rt_data_i[15:8]}};
            OP_SW: wdata_o = {rt_data_i[7:0], rt_data_i[15:8],
                              rt_data_i[23:16], rt_data_i[31:24]};
            default: wdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences CPU loads/stores onto an Avalon-MM data bus.
//   CPU side : req_valid, instruction, eff_addr, rt_data in; stall, done,
//              addr_err, bus_err out.
//   Avalon   : avm_address/read/write/byteenable/writedata out;
//              avm_waitrequest, avm_readdata in.
//   Formatter: fmt_mem_in, fmt_byteenable, fmt_mem_sel, fmt_instruction out.
// TIMEOUT_CYCLES = 0 waits forever on waitrequest.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] eff_addr,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] fmt_mem_in,
    output logic [3:0]  fmt_byteenable,
    output logic        fmt_mem_sel,
    output logic [31:0] fmt_instruction
);

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      mem_q, mem_d;
    logic [3:0]       be_q, be_d;
    logic [3:0]       fbe_q, fbe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic [5:0]  op_in;
    logic [5:0]  op_q;
    logic [1:0]  off;
    logic        mem_op;
    logic [31:0] st_wdata;

    assign op_in   = instruction[31:26];
    assign op_q    = instr_q[31:26];
    assign off     = eff_addr[1:0];
    assign mem_op  = is_load(op_in) | is_store(op_in);
    assign cnt_inc = cnt_q + CNT_ONE;

    store_align u_store_align (
        .rt_data_i (rt_data),
        .opcode_i  (op_in),
        .wdata_o   (st_wdata)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        mem_d       = mem_q;
        fbe_d       = fbe_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        done        = 1'b0;
        addr_err    = 1'b0;
        bus_err     = 1'b0;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        fmt_mem_sel = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Stall is combinational so the CPU freezes in the accept cycle.
                stall = req_valid & mem_op;
                if (req_valid && mem_op) begin
                    instr_d = instruction;
                    addr_d  = {eff_addr[31:2], 2'b00};
                    be_d    = be_for(op_in, off);
                    wdata_d = st_wdata;
                    cnt_d   = '0;
                    if (misaligned(op_in, off))
                        state_d = ST_ERR;
                    else if (is_load(op_in))
                        state_d = ST_READ;
                    else
                        state_d = ST_WRITE;
                end
            end

            ST_READ, ST_WRITE: begin
                stall     = 1'b1;
                avm_read  = (state_q == ST_READ);
                avm_write = (state_q == ST_WRITE);
                if (!avm_waitrequest) begin
                    if (state_q == ST_READ) begin
                        mem_d = avm_readdata;
                        fbe_d = be_q;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Abort on the cycle the count reaches the limit; the
                    // command drops at the following edge.
                    if (TIMEOUT_CYCLES != 0 && cnt_inc == TMO)
                        state_d = ST_TERR;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                fmt_mem_sel = is_load(op_q);
                state_d     = ST_IDLE;
            end

            ST_ERR: begin
                done     = 1'b1;
                addr_err = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_TERR: begin
                done    = 1'b1;
                bus_err = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= 32'h0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            mem_q   <= 32'h0;
            fbe_q   <= 4'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            mem_q   <= mem_d;
            fbe_q   <= fbe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign avm_address     = addr_q;
    assign avm_byteenable  = be_q;
    assign avm_writedata   = wdata_q;
    assign fmt_mem_in      = mem_q;
    assign fmt_byteenable  = fbe_q;
    assign fmt_instruction = instr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: two instances (no timeout / timeout 4) driven by the
// same stimulus; a transaction-level model predicts every output per cycle.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] instruction, eff_addr, rt_data;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    logic        stall_o [2];
    logic        done_o [2];
    logic        aerr_o [2];
    logic        berr_o [2];
    logic [31:0] addr_o [2];
    logic        rd_o [2];
    logic        wr_o [2];
    logic [3:0]  be_o [2];
    logic [31:0] wd_o [2];
    logic [31:0] fmem_o [2];
    logic [3:0]  fbe_o [2];
    logic        fsel_o [2];
    logic [31:0] finstr_o [2];

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .instruction(instruction),
        .eff_addr(eff_addr), .rt_data(rt_data), .stall(stall_o[0]), .done(done_o[0]),
        .addr_err(aerr_o[0]), .bus_err(berr_o[0]), .avm_address(addr_o[0]),
        .avm_read(rd_o[0]), .avm_write(wr_o[0]), .avm_byteenable(be_o[0]),
        .avm_writedata(wd_o[0]), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .fmt_mem_in(fmem_o[0]), .fmt_byteenable(fbe_o[0]),
        .fmt_mem_sel(fsel_o[0]), .fmt_instruction(finstr_o[0]));

    mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .instruction(instruction),
        .eff_addr(eff_addr), .rt_data(rt_data), .stall(stall_o[1]), .done(done_o[1]),
        .addr_err(aerr_o[1]), .bus_err(berr_o[1]), .avm_address(addr_o[1]),
        .avm_read(rd_o[1]), .avm_write(wr_o[1]), .avm_byteenable(be_o[1]),
        .avm_writedata(wd_o[1]), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .fmt_mem_in(fmem_o[1]), .fmt_byteenable(fbe_o[1]),
        .fmt_mem_sel(fsel_o[1]), .fmt_instruction(finstr_o[1]));

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        stall, done, aerr, berr, rd, wr, msel;
        logic        bus, wd_on, lit_be_on, lit_wd_on, lit_mem_on;
        logic [31:0] addr, wdata, mem, instr, lwd, lmem;
        logic [3:0]  be, fbe, lbe;
    } exp_t;

    exp_t        ex [2];
    bit          chk_on = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] lmem [2]   = '{32'h0, 32'h0};
    logic [3:0]  lfbe [2]   = '{4'h0, 4'h0};
    logic [31:0] linstr [2] = '{32'h0, 32'h0};
    logic [5:0]  ops [10]   = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b100110, 6'b101000, 6'b101001, 6'b101011};

    function automatic int tmo(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    function automatic bit m_load(input logic [5:0] op);
        return op inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                          6'b100100, 6'b100101, 6'b100110};
    endfunction

    function automatic bit m_store(input logic [5:0] op);
        return op inside {6'b101000, 6'b101001, 6'b101011};
    endfunction

    // access size in bytes; 0 for the partial-word LWL/LWR
    function automatic int m_size(input logic [5:0] op);
        if (op inside {6'b100000, 6'b100100, 6'b101000}) return 1;
        if (op inside {6'b100001, 6'b100101, 6'b101001}) return 2;
        if (op inside {6'b100011, 6'b101011}) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [1:0] off);
        logic [3:0] b;
        int o;
        int sz;
        o  = int'(off);
        sz = m_size(op);
        b  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (op == 6'b100010)   b[i] = (i >= 3 - o);
            else if (op == 6'b100110) b[i] = (i <= 3 - o);
            else if (sz == 1)      b[i] = (i == o);
            else if (sz == 2)      b[i] = (i / 2 == o / 2);
            else if (sz == 4)      b[i] = 1'b1;
        end
        return b;
    endfunction

    function automatic bit m_mis(input logic [5:0] op, input logic [1:0] off);
        if (m_size(op) == 2) return off[0];
        if (m_size(op) == 4) return off != 2'b00;
        return 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] rt);
        logic [31:0] w;
        int sz;
        sz = m_size(op);
        w  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (sz == 1)      w[8*i +: 8] = rt[7:0];
            else if (sz == 2) w[8*i +: 8] = (i % 2 == 1) ? rt[7:0] : rt[15:8];
            else              w[8*i +: 8] = rt[8*(3-i) +: 8];
        end
        return w;
    endfunction

    function automatic exp_t idle_exp(input int d);
        exp_t e;
        e = '{stall:0, done:0, aerr:0, berr:0, rd:0, wr:0, msel:0, bus:0, wd_on:0,
              lit_be_on:0, lit_wd_on:0, lit_mem_on:0, addr:0, wdata:0, mem:lmem[d],
              instr:linstr[d], lwd:0, lmem:0, be:0, fbe:lfbe[d], lbe:0};
        return e;
    endfunction

    // ---------------- compare process ----------------
    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk("stall", d, 32'(stall_o[d]), 32'(ex[d].stall));
                chk("done", d, 32'(done_o[d]), 32'(ex[d].done));
                chk("addr_err", d, 32'(aerr_o[d]), 32'(ex[d].aerr));
                chk("bus_err", d, 32'(berr_o[d]), 32'(ex[d].berr));
                chk("avm_read", d, 32'(rd_o[d]), 32'(ex[d].rd));
                chk("avm_write", d, 32'(wr_o[d]), 32'(ex[d].wr));
                chk("fmt_mem_sel", d, 32'(fsel_o[d]), 32'(ex[d].msel));
                chk("fmt_mem_in", d, fmem_o[d], ex[d].mem);
                chk("fmt_byteenable", d, 32'(fbe_o[d]), 32'(ex[d].fbe));
                chk("fmt_instruction", d, finstr_o[d], ex[d].instr);
                if (ex[d].bus) begin
                    chk("avm_address", d, addr_o[d], ex[d].addr);
                    chk("avm_byteenable", d, 32'(be_o[d]), 32'(ex[d].be));
                end
                if (ex[d].wd_on)      chk("avm_writedata", d, wd_o[d], ex[d].wdata);
                if (ex[d].lit_be_on)  chk("lit_byteenable", d, 32'(be_o[d]), 32'(ex[d].lbe));
                if (ex[d].lit_wd_on)  chk("lit_writedata", d, wd_o[d], ex[d].lwd);
                if (ex[d].lit_mem_on) chk("lit_fmt_mem_in", d, fmem_o[d], ex[d].lmem);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: request at k=0, then n waitrequest cycles before the
    // slave completes. Runs until both instances are back in idle.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input int n, input logic [31:0] rdata, input bit b2b,
                           input bit lit, input logic [3:0] lbe, input logic [31:0] lwd,
                           input logic [31:0] lmv);
        bit ld, st, mem, mis;
        bit to [2];
        int len [2];
        int endk [2];
        int lastk;
        logic [31:0] ins0;
        logic [3:0]  be;
        exp_t e;
        ld   = m_load(op);
        st   = m_store(op);
        mem  = ld | st;
        mis  = mem && m_mis(op, addr[1:0]);
        be   = m_be(op, addr[1:0]);
        ins0 = {op, 26'($urandom)};
        lastk = 1;
        for (int d = 0; d < 2; d++) begin
            to[d]   = mem && !mis && tmo(d) != 0 && n >= tmo(d);
            len[d]  = (!mem || mis) ? 0 : (to[d] ? tmo(d) : n + 1);
            endk[d] = !mem ? 0 : len[d] + 1;
            if (endk[d] + 1 > lastk) lastk = endk[d] + 1;
        end
        for (int k = 0; k <= lastk; k++) begin
            tick();
            req_valid = (k == 0) || (b2b && mem && endk[0] == endk[1] && k == endk[0]);
            if (k == 0)         instruction = ins0;
            else if (req_valid) instruction = {6'b100011, 26'($urandom)};
            else                instruction = $urandom;
            eff_addr        = (k == 0) ? addr : $urandom;
            rt_data         = (k == 0) ? rt : $urandom;
            avm_waitrequest = (k >= 1 && k <= n);
            avm_readdata    = (k == n + 1) ? rdata : $urandom;
            for (int d = 0; d < 2; d++) begin
                if (mem && k == 1) linstr[d] = ins0;
                if (ld && !mis && !to[d] && k == endk[d]) begin
                    lmem[d] = rdata;
                    lfbe[d] = be;
                end
                e = idle_exp(d);
                if (k == 0) begin
                    e.stall = mem;
                end else if (mem && mis && k == 1) begin
                    e.done = 1;
                    e.aerr = 1;
                end else if (mem && !mis && k <= len[d]) begin
                    e.stall = 1;
                    e.rd    = ld;
                    e.wr    = st;
                    e.bus   = 1;
                    e.addr  = {addr[31:2], 2'b00};
                    e.be    = be;
                    e.wd_on = st;
                    e.wdata = m_wdata(op, rt);
                    if (lit) begin
                        e.lit_be_on = 1;
                        e.lbe       = lbe;
                        e.lit_wd_on = st;
                        e.lwd       = lwd;
                    end
                end else if (mem && !mis && k == endk[d]) begin
                    e.done = 1;
                    e.berr = to[d];
                    e.msel = ld && !to[d];
                    if (lit && ld && !to[d]) begin
                        e.lit_mem_on = 1;
                        e.lmem       = lmv;
                    end
                end
                ex[d] = e;
            end
        end
    endtask

    // Reset while a read is waiting: the command drops at the reset edge and
    // no completion is ever reported.
    task automatic run_reset_mid();
        logic [31:0] ins0;
        exp_t e;
        ins0 = {6'b100011, 26'($urandom)};
        for (int k = 0; k <= 5; k++) begin
            tick();
            req_valid       = (k == 0);
            instruction     = (k == 0) ? ins0 : $urandom;
            eff_addr        = (k == 0) ? 32'h0000_4008 : $urandom;
            rt_data         = $urandom;
            avm_waitrequest = (k <= 2);
            avm_readdata    = $urandom;
            reset           = (k == 2);
            if (k == 1) begin
                linstr[0] = ins0;
                linstr[1] = ins0;
            end
            if (k == 3) begin
                for (int d = 0; d < 2; d++) begin
                    lmem[d] = 32'h0; lfbe[d] = 4'h0; linstr[d] = 32'h0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                e = idle_exp(d);
                if (k == 0) e.stall = 1;
                if (k == 1 || k == 2) begin
                    e.stall = 1; e.rd = 1; e.bus = 1; e.addr = 32'h0000_4008; e.be = 4'hF;
                end
                if (k == 3) begin
                    e.bus = 1; e.wd_on = 1;
                end
                ex[d] = e;
            end
        end
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          n;
        int          r;
        reset = 1; req_valid = 0; instruction = 0; eff_addr = 0; rt_data = 0;
        avm_waitrequest = 0; avm_readdata = 0;
        tick();
        tick();
        // reset held: every output, including address/data, is zero
        for (int d = 0; d < 2; d++) begin
            ex[d] = idle_exp(d);
            ex[d].bus = 1;
            ex[d].wd_on = 1;
        end
        chk_on = 1;
        tick();
        reset = 0;

        run_txn(6'b100011, 32'h0000_1004, 32'h0, 0, 32'h1122_3344, 0, 1, 4'hF, 32'h0, 32'h1122_3344);
        run_txn(6'b101000, 32'h0000_2003, 32'h0000_00AB, 0, 32'h0, 0, 1, 4'h8, 32'hABAB_ABAB, 32'h0);
        run_txn(6'b100001, 32'h0000_3001, 32'h0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        run_txn(6'b101011, 32'h0000_5000, 32'h1234_5678, 5, 32'h0, 0, 1, 4'hF, 32'h7856_3412, 32'h0);
        run_txn(6'b100011, 32'h0000_6000, 32'h0, 9, 32'hCAFE_F00D, 0, 1, 4'hF, 32'h0, 32'hCAFE_F00D);
        run_txn(6'b100010, 32'h0000_0010, 32'h0, 0, 32'h5566_7788, 0, 1, 4'h8, 32'h0, 32'h5566_7788);
        run_txn(6'b100110, 32'h0000_0013, 32'h0, 1, 32'h99AA_BBCC, 1, 1, 4'h1, 32'h0, 32'h99AA_BBCC);
        run_txn(6'b101001, 32'h0000_2002, 32'h0000_1234, 3, 32'h0, 1, 1, 4'hC, 32'h3412_3412, 32'h0);
        run_txn(6'b101011, 32'h0000_7002, 32'hDEAD_BEEF, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        run_txn(6'b000000, 32'h0000_8000, 32'h0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        run_reset_mid();
        run_txn(6'b100101, 32'h0000_9002, 32'h0, 4, 32'h0BAD_CAFE, 0, 0, 4'h0, 32'h0, 32'h0);

        for (int t = 0; t < 250; t++) begin
            r  = $urandom_range(0, 13);
            op = (r < 10) ? ops[r] : 6'($urandom);
            a  = $urandom;
            n  = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 8) : $urandom_range(0, 2);
            run_txn(op, a, $urandom, n, $urandom, ($urandom_range(0, 3) == 0), 0,
                    4'h0, 32'h0, 32'h0);
        end

        tick();
        chk_on = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
